reserved_parking_exit: RTL and testbench

Exit-side controller for the reserved (flat-allocated) parking area, the counterpart of the reserved entry path. It owns the reserved-slot occupancy register. Entry marks are applied through a set port; resident exit requests are validated, the exit gate is opened, and the slot is released once the car clears the sensor. It sits between the resident keypad/authentication logic and the exit gate actuator, and it publishes live occupancy and free-slot count.

---
 rtl/reserved_parking_exit_pkg.sv | 24 ++
 rtl/reserved_parking_exit_slot_counter.sv | 22 ++
 rtl/reserved_parking_exit.sv | 137 +++++++++++++
 tb/tb_reserved_parking_exit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reserved_parking_exit_pkg.sv
// Shared types and defaults for the reserved-area exit controller.
// State and error encodings live here so the top and the bench agree on them.
package reserved_parking_exit_pkg;

  localparam int DEFAULT_SLOTS       = 8;
  localparam int DEFAULT_FLAT_W      = 8;
  localparam int DEFAULT_GATE_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_OPEN,
    ST_RESP
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_FLAT    = 3'd1,
    ERR_AUTH    = 3'd2,
    ERR_EMPTY   = 3'd3,
    ERR_TIMEOUT = 3'd4
  } exit_err_t;

endpackage

// File: rtl/reserved_parking_exit_slot_counter.sv
// Free-slot counter: N minus the number of set occupancy bits.
// Purely combinational so the count tracks the occupancy register in the same cycle.
module slot_counter #(
  parameter int N = 8
) (
  input  logic [N-1:0]            occupancy,
  output logic [$clog2(N+1)-1:0]  free_count
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] used;

  always_comb begin
    used = '0;
    for (int i = 0; i < N; i++) begin
      used = used + CW'(occupancy[i]);
    end
    free_count = CW'(N) - used;
  end

endmodule

// File: rtl/reserved_parking_exit.sv
// Exit-side controller for the reserved parking area: validates resident exits,
// drives the exit gate and owns the reserved-slot occupancy register.
module reserved_parking_exit
  import reserved_parking_exit_pkg::*;
#(
  parameter int N           = DEFAULT_SLOTS,
  parameter int FLAT_W      = DEFAULT_FLAT_W,
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exit_req,
  input  logic [FLAT_W-1:0]       flat_number,
  input  logic                    pwd_flag,
  input  logic                    car_clear,
  input  logic                    occ_set,
  input  logic [FLAT_W-1:0]       occ_set_idx,
  output logic                    exit_ack,
  output logic                    exit_ok,
  output logic [2:0]              exit_err,
  output logic                    gate_open,
  output logic                    busy,
  output logic [N-1:0]            occupancy,
  output logic [$clog2(N+1)-1:0]  free_count
);

  localparam int TW = $clog2(GATE_CYCLES + 1);

  state_t            state, state_next;
  logic [FLAT_W-1:0] flat_q, flat_next;
  logic              pwd_q, pwd_next;
  logic [TW-1:0]     timer, timer_next;
  exit_err_t         err_q, err_next;
  logic              ok_q, ok_next;
  logic [N-1:0]      set_mask, sel_mask, clr_mask, occ_next;

  // One-hot decode of both flat ids; ids of 0 or above N match no slot.
  always_comb begin
    set_mask = '0;
    sel_mask = '0;
    for (int k = 0; k < N; k++) begin
      set_mask[k] = occ_set && (occ_set_idx == FLAT_W'(k + 1));
      sel_mask[k] = (flat_q == FLAT_W'(k + 1));
    end
  end

  always_comb begin
    state_next = state;
    flat_next  = flat_q;
    pwd_next   = pwd_q;
    timer_next = timer;
    err_next   = err_q;
    ok_next    = ok_q;
    clr_mask   = '0;
    case (state)
      ST_IDLE: begin
        if (exit_req) begin
          flat_next  = flat_number;
          pwd_next   = pwd_flag;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        ok_next    = 1'b0;
        err_next   = ERR_NONE;
        state_next = ST_RESP;
        if (sel_mask == '0) begin
          err_next = ERR_FLAT;
        end else if (!pwd_q) begin
          err_next = ERR_AUTH;
        end else if ((sel_mask & occupancy) == '0) begin
          err_next = ERR_EMPTY;
        end else begin
          timer_next = TW'(GATE_CYCLES);
          state_next = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (car_clear) begin
          clr_mask   = sel_mask;
          ok_next    = 1'b1;
          err_next   = ERR_NONE;
          state_next = ST_RESP;
        end else if (timer <= TW'(1)) begin
          ok_next    = 1'b0;
          err_next   = ERR_TIMEOUT;
          state_next = ST_RESP;
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A release in the same cycle as an entry mark on that slot leaves it empty.
  assign occ_next = (occupancy | set_mask) & ~clr_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      flat_q    <= '0;
      pwd_q     <= 1'b0;
      timer     <= '0;
      err_q     <= ERR_NONE;
      ok_q      <= 1'b0;
      occupancy <= '0;
    end else begin
      state     <= state_next;
      flat_q    <= flat_next;
      pwd_q     <= pwd_next;
      timer     <= timer_next;
      err_q     <= err_next;
      ok_q      <= ok_next;
      occupancy <= occ_next;
    end
  end

  assign gate_open = (state == ST_OPEN);
  assign busy      = (state != ST_IDLE);
  assign exit_ack  = (state == ST_RESP);
  assign exit_ok   = exit_ack && ok_q;
  assign exit_err  = exit_ack ? err_q : ERR_NONE;

  slot_counter #(
    .N (N)
  ) u_slot_counter (
    .occupancy  (occupancy),
    .free_count (free_count)
  );

endmodule

// File: tb/tb_reserved_parking_exit.sv
// Randomised self-checking bench for reserved_parking_exit against a
// transaction-level model of slot ownership, exit outcomes and gate timing.
module tb_reserved_parking_exit;

  localparam int N           = 8;
  localparam int FLAT_W      = 8;
  localparam int GATE_CYCLES = 16;
  localparam int CW          = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              exit_req;
  logic [FLAT_W-1:0] flat_number;
  logic              pwd_flag;
  logic              car_clear;
  logic              occ_set;
  logic [FLAT_W-1:0] occ_set_idx;
  logic              exit_ack;
  logic              exit_ok;
  logic [2:0]        exit_err;
  logic              gate_open;
  logic              busy;
  logic [N-1:0]      occupancy;
  logic [CW-1:0]     free_count;

  int n_checks = 0;
  int n_fails  = 0;
  bit model_occ[N];

  reserved_parking_exit #(
    .N           (N),
    .FLAT_W      (FLAT_W),
    .GATE_CYCLES (GATE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exit_req    (exit_req),
    .flat_number (flat_number),
    .pwd_flag    (pwd_flag),
    .car_clear   (car_clear),
    .occ_set     (occ_set),
    .occ_set_idx (occ_set_idx),
    .exit_ack    (exit_ack),
    .exit_ok     (exit_ok),
    .exit_err    (exit_err),
    .gate_open   (gate_open),
    .busy        (busy),
    .occupancy   (occupancy),
    .free_count  (free_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int modelWord();
    int w = 0;
    for (int k = 0; k < N; k++) if (model_occ[k]) w = w | (1 << k);
    return w;
  endfunction

  function automatic int modelFree();
    int used = 0;
    for (int k = 0; k < N; k++) used += int'(model_occ[k]);
    return N - used;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOccupancy(input string tag);
    checkOutput({tag, "_occ"}, int'(occupancy), modelWord());
    checkOutput({tag, "_free"}, int'(free_count), modelFree());
  endtask

  task automatic setSlot(input int idx);
    occ_set     = 1'b1;
    occ_set_idx = FLAT_W'(idx);
    step();
    occ_set = 1'b0;
    if (idx >= 1 && idx <= N) model_occ[idx-1] = 1'b1;
    checkOccupancy("set_slot");
  endtask

  // One exit transaction. clear_after = n-th gate-open cycle in which car_clear
  // is driven (outside 1..GATE_CYCLES means never); set_idx >= 0 pulses occ_set
  // on the set_at-th gate-open cycle.
  task automatic applyStimulus(input int flat, input bit pwd, input int clear_after,
                               input int set_idx, input int set_at);
    int  exp_err;
    int  gate_len;
    int  ack_at;
    int  gate_cnt;
    bit  exp_ok;
    bit  pend_set;
    bit  pend_clr;
    int  pend_idx;
    if (flat < 1 || flat > N)      exp_err = 1;
    else if (!pwd)                 exp_err = 2;
    else if (!model_occ[flat-1])   exp_err = 3;
    else                           exp_err = 0;
    if (exp_err != 0) begin
      gate_len = 0;
      exp_ok   = 1'b0;
    end else if (clear_after >= 1 && clear_after <= GATE_CYCLES) begin
      gate_len = clear_after;
      exp_ok   = 1'b1;
    end else begin
      gate_len = GATE_CYCLES;
      exp_ok   = 1'b0;
      exp_err  = 4;
    end
    ack_at   = 2 + gate_len;
    gate_cnt = 0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    pend_idx = 0;
    exit_req    = 1'b1;
    flat_number = FLAT_W'(flat);
    pwd_flag    = pwd;
    for (int sample = 1; sample <= ack_at; sample++) begin
      step();
      car_clear = 1'b0;
      occ_set   = 1'b0;
      if (pend_set && pend_idx >= 1 && pend_idx <= N) model_occ[pend_idx-1] = 1'b1;
      if (pend_clr) model_occ[flat-1] = 1'b0;
      pend_set = 1'b0;
      pend_clr = 1'b0;
      checkOutput("gate_open", int'(gate_open), int'(sample >= 2 && sample < ack_at));
      checkOutput("exit_ack", int'(exit_ack), int'(sample == ack_at));
      checkOutput("busy", int'(busy), 1);
      checkOccupancy("exit");
      if (gate_open) gate_cnt++;
      if (sample == ack_at) begin
        checkOutput("exit_ok", int'(exit_ok), int'(exp_ok));
        checkOutput("exit_err", int'(exit_err), exp_err);
        checkOutput("gate_cycles", gate_cnt, gate_len);
      end
      if (sample == 1) car_clear = 1'($urandom_range(0, 1));
      if (sample >= 2 && sample < ack_at) begin
        if (exp_ok && (sample - 1) == clear_after) begin
          car_clear = 1'b1;
          pend_clr  = 1'b1;
        end
        if (set_idx >= 0 && (sample - 1) == set_at) begin
          occ_set     = 1'b1;
          occ_set_idx = FLAT_W'(set_idx);
          pend_set    = 1'b1;
          pend_idx    = set_idx;
        end
      end
    end
    // Request is still high across the ack cycle and must not restart the FSM.
    car_clear = 1'($urandom_range(0, 1));
    step();
    car_clear = 1'b0;
    checkOutput("ack_pulse", int'(exit_ack), 0);
    checkOutput("idle_after_ack", int'(busy), 0);
    exit_req = 1'b0;
    step();
    checkOutput("stay_idle", int'(busy), 0);
    checkOccupancy("after_exit");
  endtask

  task automatic resetMidOpen();
    setSlot(2);
    exit_req    = 1'b1;
    flat_number = FLAT_W'(2);
    pwd_flag    = 1'b1;
    step();
    step();
    checkOutput("rst_pre_gate", int'(gate_open), 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_gate_async", int'(gate_open), 0);
    checkOutput("rst_ack", int'(exit_ack), 0);
    checkOutput("rst_busy", int'(busy), 0);
    for (int k = 0; k < N; k++) model_occ[k] = 1'b0;
    checkOccupancy("rst");
    exit_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("post_rst_ack", int'(exit_ack), 0);
      checkOutput("post_rst_busy", int'(busy), 0);
    end
  endtask

  initial begin
    int flat;
    int ca;
    int si;
    int sa;
    rst         = 1'b1;
    exit_req    = 1'b0;
    flat_number = '0;
    pwd_flag    = 1'b0;
    car_clear   = 1'b0;
    occ_set     = 1'b0;
    occ_set_idx = '0;
    for (int k = 0; k < N; k++) model_occ[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gate", int'(gate_open), 0);
    checkOutput("reset_ack", int'(exit_ack), 0);
    checkOutput("reset_ok", int'(exit_ok), 0);
    checkOutput("reset_err", int'(exit_err), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOccupancy("reset");
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("[TB] directed scenarios");
    setSlot(3);
    applyStimulus(3, 1'b1, 4, -1, 0);
    applyStimulus(0, 1'b1, 4, -1, 0);
    applyStimulus(9, 1'b1, 4, -1, 0);
    setSlot(3);
    applyStimulus(3, 1'b0, 4, -1, 0);
    applyStimulus(5, 1'b1, 4, -1, 0);
    setSlot(2);
    applyStimulus(2, 1'b1, 0, -1, 0);
    setSlot(4);
    applyStimulus(4, 1'b1, 5, 4, 5);
    applyStimulus(2, 1'b1, 8, 6, 3);
    setSlot(0);
    setSlot(9);
    setSlot(6);
    applyStimulus(3, 1'b1, GATE_CYCLES, -1, 0);

    $display("[TB] reset during open gate");
    resetMidOpen();
    setSlot(1);
    applyStimulus(1, 1'b1, 3, -1, 0);

    $display("[TB] randomised traffic");
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        setSlot($urandom_range(0, N + 1));
      end else begin
        flat = $urandom_range(0, N + 1);
        ca   = $urandom_range(0, GATE_CYCLES + 2);
        si   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, N + 1) : -1;
        sa   = $urandom_range(1, (ca >= 1) ? ca : 4);
        applyStimulus(flat, 1'($urandom_range(0, 3) != 0), ca, si, sa);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
